// File: rtl/pipelined_fetch_unit.sv
// Instruction-fetch stage: PC register with prioritised redirect select,
// IF/ID pipeline register with stall/flush, and a circular return-address
// stack used by the jal/jr decode logic. Instruction memory is external
// and combinational: address goes out, instruction comes back this cycle.
// rst_i is an asynchronous, active-low reset despite its name.
module pipelined_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               br_taken_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  input  logic               jr_i,
  input  logic [ADDR_W-1:0]  jr_target_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_target_i,
  input  logic               ras_push_i,
  input  logic [ADDR_W-1:0]  ras_push_data_i,
  input  logic               ras_pop_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [ADDR_W-1:0]  ifid_pc_plus4_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ras_top_o,
  output logic               ras_empty_o,
  output logic               ras_overflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  redirect_target;
  logic               redirect;

  logic [ADDR_W-1:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;

  logic [ADDR_W-1:0]  ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;
  logic               ras_ovf_q, ras_ovf_d;

  // Next-PC select and IF/ID update. A redirect wins over stall; the
  // instruction fetched alongside a redirect or flush is wrong-path, so
  // IF/ID takes a bubble instead.
  always_comb begin
    pc_plus4        = pc_q + ADDR_W'(4);
    redirect        = br_taken_i | jr_i | jump_i;
    redirect_target = br_taken_i ? br_target_i :
                      jr_i       ? jr_target_i : jump_target_i;

    pc_d            = pc_plus4;
    ifid_pc_plus4_d = pc_plus4;
    ifid_instr_d    = imem_instr_i;
    ifid_valid_d    = 1'b1;

    if (redirect) begin
      // Targets are taken as given; low bits dropped to stay word-aligned.
      pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (stall_i) begin
      pc_d = pc_q;
    end

    if (redirect || flush_i) begin
      ifid_pc_plus4_d = '0;
      ifid_instr_d    = '0;
      ifid_valid_d    = 1'b0;
    end else if (stall_i) begin
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_valid_d    = ifid_valid_q;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q            <= RESET_PC;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= '0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  // Return-address stack update. Push+pop replaces the top entry (or acts
  // as a plain push when empty); a push while full overwrites the oldest
  // entry, which sits just above the top in the circular buffer.
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_ovf_d = ras_ovf_q;

    if (ras_push_i && ras_pop_i && (ras_cnt_q != '0)) begin
      ras_mem_d[ras_ptr_q] = ras_push_data_i;
    end else if (ras_push_i) begin
      ras_ptr_d            = ras_ptr_q + PTR_W'(1);
      ras_mem_d[ras_ptr_d] = ras_push_data_i;
      if (ras_cnt_q == CNT_FULL) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end else if (ras_pop_i && (ras_cnt_q != '0)) begin
      ras_ptr_d = ras_ptr_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  // Return-address stack registers; not affected by stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_valid_o    = ifid_valid_q;
  // Stack outputs depend only on registered state.
  assign ras_empty_o     = (ras_cnt_q == '0);
  assign ras_top_o       = ras_empty_o ? '0 : ras_mem_q[ras_ptr_q];
  assign ras_overflow_o  = ras_ovf_q;

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Bench for pipelined_fetch_unit: directed scenarios followed by random
// stimulus, all compared against a queue-based reference model.
module tb_pipelined_fetch_unit;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT signals ----------------
  logic        stall, flush, br_taken, jr, jump, ras_push, ras_pop;
  logic [31:0] br_target, jr_target, jump_target, ras_push_data;
  logic [31:0] imem_addr, imem_instr, ifid_pc4, ifid_instr, ras_top;
  logic        ifid_valid, ras_empty, ras_ovf;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = instr_of(imem_addr);

  pipelined_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
    .br_taken_i(br_taken), .br_target_i(br_target),
    .jr_i(jr), .jr_target_i(jr_target),
    .jump_i(jump), .jump_target_i(jump_target),
    .ras_push_i(ras_push), .ras_push_data_i(ras_push_data), .ras_pop_i(ras_pop),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .ifid_pc_plus4_o(ifid_pc4), .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid),
    .ras_top_o(ras_top), .ras_empty_o(ras_empty), .ras_overflow_o(ras_ovf)
  );

  // ---------------- narrow DUT for PC wrap ----------------
  logic        w_zero = 1'b0;
  logic [7:0]  w_zero8 = 8'h00;
  logic [31:0] w_instr_in = 32'h0;
  logic [7:0]  w_addr, w_pc4, w_top;
  logic [31:0] w_instr;
  logic        w_valid, w_empty, w_ovf;

  pipelined_fetch_unit #(
    .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .RAS_DEPTH(2)
  ) dut_w (
    .clk_i(clk), .rst_i(rst_n), .stall_i(w_zero), .flush_i(w_zero),
    .br_taken_i(w_zero), .br_target_i(w_zero8),
    .jr_i(w_zero), .jr_target_i(w_zero8),
    .jump_i(w_zero), .jump_target_i(w_zero8),
    .ras_push_i(w_zero), .ras_push_data_i(w_zero8), .ras_pop_i(w_zero),
    .imem_addr_o(w_addr), .imem_instr_i(w_instr_in),
    .ifid_pc_plus4_o(w_pc4), .ifid_instr_o(w_instr), .ifid_valid_o(w_valid),
    .ras_top_o(w_top), .ras_empty_o(w_empty), .ras_overflow_o(w_ovf)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_ovf;
  logic [31:0] exp_q[$];   // return-address stack, newest at the back

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h100; m_pc4 = '0; m_instr = '0; m_valid = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Applies the current inputs to the model as the next clock edge will.
  task automatic model_update();
    logic        redir;
    logic [31:0] tgt, seq;
    redir = br_taken | jr | jump;
    tgt   = br_taken ? br_target : (jr ? jr_target : jump_target);
    seq   = m_pc + 32'd4;
    if (redir || flush) begin
      m_valid = 1'b0; m_pc4 = '0; m_instr = '0;
    end else if (!stall) begin
      m_valid = 1'b1; m_pc4 = seq; m_instr = instr_of(m_pc);
    end
    if (redir)       m_pc = tgt & ~32'h3;
    else if (!stall) m_pc = seq;
    if (ras_push && ras_pop && exp_q.size() > 0) begin
      exp_q[exp_q.size()-1] = ras_push_data;
    end else if (ras_push) begin
      if (exp_q.size() == DEPTH) begin
        void'(exp_q.pop_front());
        m_ovf = 1'b1;
      end
      exp_q.push_back(ras_push_data);
    end else if (ras_pop && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
    end
  endtask

  task automatic compare_all();
    logic [31:0] top;
    top = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 32'h0;
    check_eq("imem_addr",  imem_addr,  m_pc);
    check_eq("ifid_valid", ifid_valid, m_valid);
    check_eq("ifid_pc4",   ifid_pc4,   m_pc4);
    check_eq("ifid_instr", ifid_instr, m_instr);
    check_eq("ras_top",    ras_top,    top);
    check_eq("ras_empty",  ras_empty,  exp_q.size() == 0);
    check_eq("ras_ovf",    ras_ovf,    m_ovf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    stall = 0; flush = 0; br_taken = 0; jr = 0; jump = 0;
    ras_push = 0; ras_pop = 0;
    br_target = '0; jr_target = '0; jump_target = '0; ras_push_data = '0;
  endtask

  // Inputs are set before calling; one clock edge, then check mid-low phase.
  task automatic cycle();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [31:0] d);
    clear_inputs(); ras_push = 1; ras_push_data = d; cycle(); clear_inputs();
  endtask

  task automatic pop();
    clear_inputs(); ras_pop = 1; cycle(); clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_eq("rst_pc_const", imem_addr, 32'h100);
    check_eq("w_rst_pc", w_addr, 8'hF8);
    rst_n = 1'b1;

    // Free run from reset.
    cycle();
    check_eq("run_pc1", imem_addr, 32'h104);
    check_eq("run_valid1", ifid_valid, 1'b1);
    check_eq("run_pc4_1", ifid_pc4, 32'h104);
    check_eq("w_pc1", w_addr, 8'hFC);
    cycle();
    check_eq("run_pc2", imem_addr, 32'h108);
    check_eq("w_wrap_pc", w_addr, 8'h00);
    check_eq("w_wrap_pc4", w_pc4, 8'h00);

    // Two-cycle stall at 0x108.
    stall = 1; cycle(); cycle();
    check_eq("stall_pc", imem_addr, 32'h108);
    check_eq("stall_pc4", ifid_pc4, 32'h108);
    stall = 0; cycle();
    check_eq("resume_pc", imem_addr, 32'h10C);

    // Branch beats jump and stall.
    br_taken = 1; br_target = 32'h200; jump = 1; jump_target = 32'h300; stall = 1;
    cycle();
    check_eq("br_pc", imem_addr, 32'h200);
    check_eq("br_bubble", ifid_valid, 1'b0);
    clear_inputs(); cycle();
    check_eq("br_next_pc", imem_addr, 32'h204);
    check_eq("br_next_valid", ifid_valid, 1'b1);

    // Unaligned jr target.
    jr = 1; jr_target = 32'h0000_0123; cycle(); clear_inputs();
    check_eq("jr_align", imem_addr, 32'h120);

    // Flush alone.
    flush = 1; cycle(); clear_inputs();
    check_eq("flush_pc", imem_addr, 32'h124);
    check_eq("flush_bubble", ifid_valid, 1'b0);

    // RAS overflow and drain.
    for (int i = 0; i < 5; i++) push(32'h1000 + 32'(i) * 32'h10);
    check_eq("ras_top_E", ras_top, 32'h1040);
    check_eq("ras_ovf_set", ras_ovf, 1'b1);
    pop(); check_eq("ras_pop_D", ras_top, 32'h1030);
    pop(); check_eq("ras_pop_C", ras_top, 32'h1020);
    pop(); check_eq("ras_pop_B", ras_top, 32'h1010);
    pop(); check_eq("ras_drained", ras_empty, 1'b1);
    pop(); check_eq("ras_empty_pop", ras_empty, 1'b1);
    check_eq("ras_empty_top", ras_top, 32'h0);

    // Replace on top.
    push(32'h2000); push(32'h2010);
    clear_inputs(); ras_push = 1; ras_pop = 1; ras_push_data = 32'h2020; cycle(); clear_inputs();
    check_eq("ras_replace", ras_top, 32'h2020);
    pop(); check_eq("ras_after_replace", ras_top, 32'h2000);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      br_taken      = ($urandom_range(0, 9) == 0);
      jr            = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      br_target     = $urandom;
      jr_target     = $urandom;
      jump_target   = $urandom;
      ras_push      = ($urandom_range(0, 3) == 0);
      ras_pop       = ($urandom_range(0, 3) == 0);
      ras_push_data = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_fetch_unit.md
Name: pipelined_fetch_unit

Overview:
Instruction-fetch stage for the pipelined MIPS core. It replaces the single-cycle PC, PC+4 adder and next-PC mux chain with a parametrised PC register, a prioritised redirect select and an IF/ID pipeline register with stall/flush. It also contains a configurable-depth return-address stack (RAS) that jal/jr decode logic uses. Instruction memory stays external and combinational: address out, instruction back in the same cycle.

Parameters:
ADDR_W, 32, PC/address width in bits (>= 8)
INSTR_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset (ADDR_W bits, word-aligned)
RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-low reset
stall_i  input  1  hazard stall: hold PC and IF/ID
flush_i  input  1  kill IF/ID contents next edge
br_taken_i  input  1  branch resolved taken (from EX)
br_target_i  input  ADDR_W  branch target
jr_i  input  1  jr in decode
jr_target_i  input  ADDR_W  register target for jr
jump_i  input  1  j/jal in decode
jump_target_i  input  ADDR_W  concatenated jump target
ras_push_i  input  1  push link address (jal)
ras_push_data_i  input  ADDR_W  link value (PC+4 of jal)
ras_pop_i  input  1  pop (jr $ra)
imem_addr_o  output  ADDR_W  current PC to instruction memory
imem_instr_i  input  INSTR_W  fetched instruction
ifid_pc_plus4_o  output  ADDR_W  registered PC+4
ifid_instr_o  output  INSTR_W  registered instruction
ifid_valid_o  output  1  IF/ID holds a real instruction
ras_top_o  output  ADDR_W  top-of-stack value (0 when empty)
ras_empty_o  output  1  stack empty
ras_overflow_o  output  1  sticky: a push dropped the oldest entry

Behaviour:
- Reset (rst_i=0, asynchronous): PC=RESET_PC; ifid_pc_plus4_o=0, ifid_instr_o=0, ifid_valid_o=0; RAS count=0, ras_top_o=0, ras_empty_o=1, ras_overflow_o=0. Reset asserted mid-operation discards all state immediately.
- imem_addr_o = PC combinationally. pc_plus4 = PC + 4, truncated to ADDR_W (wraps at 2^ADDR_W).
- Next-PC priority, highest first: br_taken_i -> br_target_i; jr_i -> jr_target_i; jump_i -> jump_target_i; stall_i -> hold PC; else pc_plus4.
- A redirect (br_taken_i | jr_i | jump_i) overrides stall_i. PC loads the target. IF/ID loads a bubble (valid=0, instr=0, pc_plus4=0) because the instruction fetched in that cycle is on the wrong path.
- flush_i without a redirect: PC advances normally (or holds if stall_i). IF/ID loads a bubble.
- stall_i alone: PC and IF/ID hold all values, including valid.
- Otherwise: IF/ID <= {pc_plus4, imem_instr_i, valid=1}. Fetch-to-decode latency is 1 cycle.
- Targets are used as given. Bits [1:0] are forced to 0 on PC load, so PC stays word-aligned.
- RAS is a circular buffer with a top pointer and count (0..RAS_DEPTH):
  - Push only: write at top+1, advance pointer, count++. When count==RAS_DEPTH, the oldest entry is overwritten, count stays saturated and ras_overflow_o sets (sticky until reset).
  - Pop only: pointer--, count--. Pop on empty is ignored: no pointer change, no error.
  - Push and pop together: the top entry is replaced with the push data; pointer and count are unchanged (replace on empty behaves as a push).
  - The RAS ignores stall_i; the decode logic gates push/pop.
- ras_top_o is the entry at the pointer when count>0, else 0. ras_empty_o = (count==0). Both are registered-state derived with no combinational path from push/pop inputs.

Test Plan:
- Reset then free-run, RESET_PC=0x100: imem_addr_o steps 0x100, 0x104, 0x108. The first edge after reset sets ifid_valid_o=1 with ifid_pc_plus4_o=0x104.
- stall_i high for 2 cycles at PC=0x108: PC and IF/ID frozen for 2 edges, then resume at 0x10C.
- Same cycle br_taken_i=1 (0x200), jump_i=1 (0x300), stall_i=1: PC=0x200 next, ifid_valid_o=0. Next cycle without redirect: PC=0x204, valid=1.
- jr_target_i=0x0000_0123 with jr_i: PC=0x120 (low bits cleared). With ADDR_W=8, PC=0xFC sequential wraps to 0x00.
- RAS_DEPTH=4: push A, B, C, D, E gives ras_top_o=E, ras_overflow_o=1. Four pops give D, C, B, then empty (A lost). A fifth pop leaves state unchanged.
- Simultaneous push X and pop with top=B, count=2: top=X, count=2. Pop gives A.
